// File: rtl/spatz_boot_ctrl.sv
// Spatz cluster boot sequencer: after a settle delay it writes the entry point to the boot-control register, then wakes the cores.
// Optional response watchdog: define SPATZ_BOOT_CTRL_TIMEOUT_EN.
module spatz_boot_ctrl #(
   parameter int unsigned                NumCores      = 4,
   parameter int unsigned                AddrWidth     = 48,
   parameter logic [AddrWidth-1:0]       BootCtrlAddr  = '0,
   parameter int unsigned                WaitCycles    = 1000,
   parameter int unsigned                TimeoutCycles = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic [31:0]          entry_point_i,
   output logic [AddrWidth-1:0] q_addr_o,
   output logic [63:0]          q_data_o,
   output logic                 q_write_o,
   output logic [7:0]           q_strb_o,
   output logic                 q_valid_o,
   input  logic                 q_ready_i,
   input  logic                 p_valid_i,
   input  logic                 p_error_i,
   output logic                 p_ready_o,
   output logic [NumCores-1:0]  debug_req_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 error_o
);

   localparam int unsigned CntW = (WaitCycles > 0) ? $clog2(WaitCycles + 1) : 1;

   typedef enum logic [2:0] {
      IDLE, WAIT, REQ, RESP, WAKE, DONE, ERR
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [31:0]       entry_q, entry_d;

   logic [AddrWidth-1:0] q_addr_q;
   logic [63:0]          q_data_q;
   logic                 q_write_q, q_valid_q, p_ready_q;
   logic [7:0]           q_strb_q;
   logic [NumCores-1:0]  debug_req_q;
   logic                 busy_q, done_q, error_q;

`ifdef SPATZ_BOOT_CTRL_TIMEOUT_EN
   localparam int unsigned TmoW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam int unsigned TmoLoad = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
   logic [TmoW-1:0] wdog_q, wdog_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      entry_d = entry_q;
`ifdef SPATZ_BOOT_CTRL_TIMEOUT_EN
      wdog_d  = wdog_q;
`endif
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start_i) begin
               entry_d = entry_point_i;
               cnt_d   = CntW'(WaitCycles);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) state_d = REQ;
            else             cnt_d   = cnt_q - CntW'(1);
         end
         REQ: begin
            if (q_valid_q && q_ready_i) begin
               state_d = RESP;
`ifdef SPATZ_BOOT_CTRL_TIMEOUT_EN
               wdog_d  = TmoW'(TmoLoad);
`endif
            end
         end
         RESP: begin
            if (p_valid_i) begin
               state_d = p_error_i ? ERR : WAKE;
            end
`ifdef SPATZ_BOOT_CTRL_TIMEOUT_EN
            else if (wdog_q == '0) begin
               state_d = ERR;
            end else begin
               wdog_d = wdog_q - TmoW'(1);
            end
`endif
         end
         WAKE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q without decode logic.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         entry_q     <= '0;
         q_addr_q    <= '0;
         q_data_q    <= '0;
         q_write_q   <= 1'b0;
         q_strb_q    <= '0;
         q_valid_q   <= 1'b0;
         p_ready_q   <= 1'b0;
         debug_req_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
`ifdef SPATZ_BOOT_CTRL_TIMEOUT_EN
         wdog_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         entry_q     <= entry_d;
         q_addr_q    <= (state_d == REQ) ? BootCtrlAddr : '0;
         q_data_q    <= (state_d == REQ) ? {32'b0, entry_d} : '0;
         q_write_q   <= (state_d == REQ);
         q_strb_q    <= (state_d == REQ) ? 8'hff : 8'h00;
         q_valid_q   <= (state_d == REQ);
         p_ready_q   <= (state_d == RESP);
         debug_req_q <= {NumCores{state_d == WAKE}};
         busy_q      <= (state_d == WAIT) || (state_d == REQ) ||
                        (state_d == RESP) || (state_d == WAKE);
         done_q      <= (state_d == DONE);
         error_q     <= (state_d == ERR);
`ifdef SPATZ_BOOT_CTRL_TIMEOUT_EN
         wdog_q      <= wdog_d;
`endif
      end
   end

   assign q_addr_o    = q_addr_q;
   assign q_data_o    = q_data_q;
   assign q_write_o   = q_write_q;
   assign q_strb_o    = q_strb_q;
   assign q_valid_o   = q_valid_q;
   assign p_ready_o   = p_ready_q;
   assign debug_req_o = debug_req_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign error_o     = error_q;

endmodule

// File: tb/tb_spatz_boot_ctrl.sv
// Directed self-checking bench for spatz_boot_ctrl (WaitCycles=4, TimeoutCycles=16).
module tb_spatz_boot_ctrl;

   localparam int unsigned NC   = 4;
   localparam int unsigned AW   = 48;
   localparam logic [AW-1:0] BOOT_ADDR = 48'h0001_0200_0040;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [31:0]   entry = '0;
   logic [AW-1:0] q_addr;
   logic [63:0]   q_data;
   logic          q_write, q_valid;
   logic [7:0]    q_strb;
   logic          q_ready = 1'b0;
   logic          p_valid = 1'b0;
   logic          p_error = 1'b0;
   logic          p_ready;
   logic [NC-1:0] debug_req;
   logic          busy, done, error;

   int total = 0;
   int bad   = 0;
   int hs_cnt = 0;
   int dbg_cnt = 0;

   spatz_boot_ctrl #(
      .NumCores(NC), .AddrWidth(AW), .BootCtrlAddr(BOOT_ADDR),
      .WaitCycles(4), .TimeoutCycles(16)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .entry_point_i(entry),
      .q_addr_o(q_addr), .q_data_o(q_data), .q_write_o(q_write), .q_strb_o(q_strb),
      .q_valid_o(q_valid), .q_ready_i(q_ready), .p_valid_i(p_valid), .p_error_i(p_error),
      .p_ready_o(p_ready), .debug_req_o(debug_req), .busy_o(busy), .done_o(done),
      .error_o(error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (q_valid && q_ready) hs_cnt = hs_cnt + 1;
      if (debug_req != '0)    dbg_cnt = dbg_cnt + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] e);
      start = 1'b1;
      entry = e;
      step();
      start = 1'b0;
   endtask

   task automatic wait_qvalid(input string tag);
      for (int i = 0; i < 40 && !q_valid; i++) step();
      total++;
      if (q_valid !== 1'b1) begin
         bad++; $display("FAIL %s_wait_qvalid: got %b want 1", tag, q_valid);
      end
   endtask

   task automatic test_reset();
      #3;
      total++;
      if ({q_valid, p_ready, debug_req, busy, done, error, q_write, q_strb} !== '0 ||
          q_addr !== '0 || q_data !== '0) begin
         bad++; $display("FAIL reset_outputs: q_valid=%b p_ready=%b dbg=%h busy=%b done=%b err=%b addr=%h data=%h",
                         q_valid, p_ready, debug_req, busy, done, error, q_addr, q_data);
      end
      @(negedge clk); rst_n = 1'b1;
      step(); step();
      total++;
      if ({q_valid, busy, done, error} !== 4'b0) begin
         bad++; $display("FAIL reset_idle: got %b want 0000", {q_valid, busy, done, error});
      end
   endtask

   task automatic test_basic();
      int hs0 = hs_cnt;
      int d0  = dbg_cnt;
      q_ready = 1'b1; p_valid = 1'b1; p_error = 1'b0;
      do_start(32'h8000_0000);            // now in T+1
      total++;
      if (busy !== 1'b1 || q_valid !== 1'b0) begin
         bad++; $display("FAIL basic_t1: busy=%b q_valid=%b want 1/0", busy, q_valid);
      end
      repeat (4) step();                  // T+5
      total++;
      if (q_valid !== 1'b0) begin
         bad++; $display("FAIL basic_t5_qvalid: got %b want 0", q_valid);
      end
      step();                             // T+6
      total++;
      if (q_valid !== 1'b1 || q_write !== 1'b1 || q_strb !== 8'hff) begin
         bad++; $display("FAIL basic_t6_ctrl: valid=%b write=%b strb=%h want 1/1/ff", q_valid, q_write, q_strb);
      end
      total++;
      if (q_addr !== BOOT_ADDR) begin
         bad++; $display("FAIL basic_addr: got %h want %h", q_addr, BOOT_ADDR);
      end
      total++;
      if (q_data !== 64'h0000_0000_8000_0000) begin
         bad++; $display("FAIL basic_data: got %h want 0000000080000000", q_data);
      end
      step();                             // T+7
      total++;
      if (p_ready !== 1'b1 || debug_req !== 4'h0 || q_valid !== 1'b0) begin
         bad++; $display("FAIL basic_t7: p_ready=%b dbg=%h q_valid=%b want 1/0/0", p_ready, debug_req, q_valid);
      end
      step();                             // T+8
      total++;
      if (debug_req !== 4'hf) begin
         bad++; $display("FAIL basic_t8_debug: got %h want f", debug_req);
      end
      step();                             // T+9
      total++;
      if (debug_req !== 4'h0 || done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
         bad++; $display("FAIL basic_t9: dbg=%h done=%b busy=%b err=%b want 0/1/0/0", debug_req, done, busy, error);
      end
      total++;
      if (hs_cnt - hs0 !== 1 || dbg_cnt - d0 !== 1) begin
         bad++; $display("FAIL basic_counts: hs=%0d dbg=%0d want 1/1", hs_cnt - hs0, dbg_cnt - d0);
      end
   endtask

   task automatic test_backpressure();
      int hs0 = hs_cnt;
      int d0  = dbg_cnt;
      q_ready = 1'b0; p_valid = 1'b1; p_error = 1'b0;
      do_start(32'h1234_5678);
      wait_qvalid("bp");
      for (int i = 0; i < 10; i++) begin
         total++;
         if (q_valid !== 1'b1 || q_addr !== BOOT_ADDR || q_data !== 64'h0000_0000_1234_5678 ||
             q_write !== 1'b1 || q_strb !== 8'hff) begin
            bad++; $display("FAIL bp_hold[%0d]: valid=%b addr=%h data=%h write=%b strb=%h",
                            i, q_valid, q_addr, q_data, q_write, q_strb);
         end
         step();
      end
      q_ready = 1'b1;
      step(); step(); step();
      total++;
      if (done !== 1'b1 || hs_cnt - hs0 !== 1 || dbg_cnt - d0 !== 1) begin
         bad++; $display("FAIL bp_end: done=%b hs=%0d dbg=%0d want 1/1/1", done, hs_cnt - hs0, dbg_cnt - d0);
      end
   endtask

   task automatic test_error();
      int d0 = dbg_cnt;
      q_ready = 1'b1; p_valid = 1'b1; p_error = 1'b1;
      do_start(32'h8000_0000);
      total++;
      if (done !== 1'b0) begin
         bad++; $display("FAIL err_done_clear: got %b want 0", done);
      end
      for (int i = 0; i < 40 && !error; i++) step();
      total++;
      if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL err_state: err=%b done=%b busy=%b want 1/0/0", error, done, busy);
      end
      total++;
      if (dbg_cnt - d0 !== 0) begin
         bad++; $display("FAIL err_no_wake: got %0d pulses want 0", dbg_cnt - d0);
      end
      p_error = 1'b0;
   endtask

   task automatic test_restart();
      int hs0 = hs_cnt;
      q_ready = 1'b1; p_valid = 1'b1; p_error = 1'b0;
      do_start(32'h8000_0000);
      total++;
      if (error !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL rs_err_clear: err=%b busy=%b want 0/1", error, busy);
      end
      step();
      do_start(32'hdead_beef);            // ignored while in WAIT
      wait_qvalid("rs1");
      total++;
      if (q_data !== 64'h0000_0000_8000_0000) begin
         bad++; $display("FAIL rs_ignored_entry: got %h want 0000000080000000", q_data);
      end
      for (int i = 0; i < 20 && !done; i++) step();
      total++;
      if (done !== 1'b1 || hs_cnt - hs0 !== 1) begin
         bad++; $display("FAIL rs_one_req: done=%b hs=%0d want 1/1", done, hs_cnt - hs0);
      end
      do_start(32'h8000_1000);
      total++;
      if (done !== 1'b0) begin
         bad++; $display("FAIL rs_done_clear: got %b want 0", done);
      end
      wait_qvalid("rs2");
      total++;
      if (q_data !== 64'h0000_0000_8000_1000) begin
         bad++; $display("FAIL rs_second_data: got %h want 0000000080001000", q_data);
      end
      for (int i = 0; i < 20 && !done; i++) step();
      total++;
      if (done !== 1'b1 || hs_cnt - hs0 !== 2) begin
         bad++; $display("FAIL rs_second_done: done=%b hs=%0d want 1/2", done, hs_cnt - hs0);
      end
   endtask

   task automatic test_reset_in_resp();
      int hs0 = hs_cnt;
      q_ready = 1'b1; p_valid = 1'b0;
      do_start(32'h8000_2000);
      for (int i = 0; i < 40 && !p_ready; i++) step();
      total++;
      if (p_ready !== 1'b1) begin
         bad++; $display("FAIL rr_reach_resp: p_ready=%b want 1", p_ready);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({q_valid, p_ready, debug_req, busy, done, error, q_write, q_strb} !== '0 ||
          q_addr !== '0 || q_data !== '0) begin
         bad++; $display("FAIL rr_async_clear: p_ready=%b busy=%b q_valid=%b addr=%h", p_ready, busy, q_valid, q_addr);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if ({q_valid, busy, p_ready} !== 3'b000) begin
            bad++; $display("FAIL rr_idle[%0d]: valid/busy/p_ready=%b want 000", i, {q_valid, busy, p_ready});
         end
      end
      total++;
      if (hs_cnt - hs0 !== 1) begin
         bad++; $display("FAIL rr_hs: got %0d want 1", hs_cnt - hs0);
      end
   endtask

   task automatic test_timeout();
      q_ready = 1'b1; p_valid = 1'b0;
      do_start(32'h8000_3000);
      for (int i = 0; i < 40 && !p_ready; i++) step();   // first RESP cycle R
`ifdef SPATZ_BOOT_CTRL_TIMEOUT_EN
      repeat (15) step();
      total++;
      if (error !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL to_early: err=%b busy=%b want 0/1", error, busy);
      end
      step();
      total++;
      if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL to_expire: err=%b busy=%b done=%b want 1/0/0", error, busy, done);
      end
`else
      repeat (1000) step();
      total++;
      if (busy !== 1'b1 || p_ready !== 1'b1 || error !== 1'b0) begin
         bad++; $display("FAIL to_wait_forever: busy=%b p_ready=%b err=%b want 1/1/0", busy, p_ready, error);
      end
`endif
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_error();
      test_restart();
      test_reset_in_resp();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
